sand_brush_painter: RTL

Paints a user-selected cell type into the simulation RAM as a square brush stroke at the cursor position. It sits directly downstream of the game state controller and consumes that controller's `draw_en_o`, which is high only while the frame loop is in its wait window. It writes through the same RAM write port that the next-state engine uses outside that window. One RAM write is issued per cycle, with clipping at the playfield edges. The controller's VRAM copy reads RAM afterwards, so painted cells appear on the next displayed frame.

---
 rtl/sand_brush_painter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sand_brush_painter.sv
// sand_brush_painter
//
// Paints cell_type_i into the simulation RAM as a square brush stroke. The
// stroke's top-left corner is the cursor. The stroke is clipped at the
// playfield edges. The block writes one cell per clock and only while
// draw_en_i is high. If draw_en_i drops mid-stroke, the rest of the stroke is
// dropped.
//
// Optional feature macro: SAND_BRUSH_SCATTER_EN. When it is defined, an LFSR
// gates roughly a quarter of the writes, which gives a granular sand fill.
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   draw_en_i        paint permission (controller wait window)
//   cursor_x_i       brush top-left column
//   cursor_y_i       brush top-left row
//   brush_size_i     brush side length, 0 = no stroke
//   cell_type_i      value to paint
//   ram_wr_address_o RAM write address (0 outside PAINT)
//   ram_wr_data_o    RAM write data (0 outside PAINT)
//   ram_wr_en_o      RAM write strobe
//   busy_o           high in PAINT and DONE
//   done_o           one-cycle pulse when a stroke completes
module sand_brush_painter #(
  parameter int unsigned ACTIVE_COLUMNS = 640,
  parameter int unsigned ACTIVE_ROWS    = 480,
  parameter int unsigned ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int unsigned DATA_WIDTH     = 2,
  parameter int unsigned BRUSH_MAX      = 8,
  parameter int unsigned X_WIDTH        = $clog2(ACTIVE_COLUMNS),
  parameter int unsigned Y_WIDTH        = $clog2(ACTIVE_ROWS),
  parameter int unsigned SIZE_WIDTH     = $clog2(BRUSH_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  draw_en_i,
  input  logic [X_WIDTH-1:0]    cursor_x_i,
  input  logic [Y_WIDTH-1:0]    cursor_y_i,
  input  logic [SIZE_WIDTH-1:0] brush_size_i,
  input  logic [DATA_WIDTH-1:0] cell_type_i,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StPaint, StDone} state_e;

  localparam logic [X_WIDTH:0]      ColsExt   = (X_WIDTH + 1)'(ACTIVE_COLUMNS);
  localparam logic [Y_WIDTH:0]      RowsExt   = (Y_WIDTH + 1)'(ACTIVE_ROWS);
  localparam logic [ADDR_WIDTH-1:0] RowStride = ADDR_WIDTH'(ACTIVE_COLUMNS);

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    x_q, x_d, x0_q, x0_d, x_last_q, x_last_d;
  logic [Y_WIDTH-1:0]    y_q, y_d, y_last_q, y_last_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [X_WIDTH:0]      x_end;
  logic [Y_WIDTH:0]      y_end;
  logic [ADDR_WIDTH-1:0] origin_base;
  logic                  req_ok;
  logic                  scatter_ok;

  // Clipped extent and row base of a new request. The row base is the only
  // multiply in the block, and it is evaluated only at latch.
  always_comb begin
    x_end = {1'b0, cursor_x_i} + (X_WIDTH + 1)'(brush_size_i);
    if (x_end > ColsExt) x_end = ColsExt;
    y_end = {1'b0, cursor_y_i} + (Y_WIDTH + 1)'(brush_size_i);
    if (y_end > RowsExt) y_end = RowsExt;
    origin_base = ADDR_WIDTH'(cursor_y_i) * RowStride;
    req_ok = (brush_size_i != '0) && ({1'b0, cursor_x_i} < ColsExt) &&
             ({1'b0, cursor_y_i} < RowsExt);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    x0_d       = x0_q;
    x_last_d   = x_last_q;
    y_d        = y_q;
    y_last_d   = y_last_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        if (draw_en_i && req_ok) begin
          state_d    = StPaint;
          x0_d       = cursor_x_i;
          x_d        = cursor_x_i;
          y_d        = cursor_y_i;
          x_last_d   = X_WIDTH'(x_end - (X_WIDTH + 1)'(1));
          y_last_d   = Y_WIDTH'(y_end - (Y_WIDTH + 1)'(1));
          row_base_d = origin_base;
          addr_d     = origin_base + ADDR_WIDTH'(cursor_x_i);
          data_d     = cell_type_i;
        end
      end
      StPaint: begin
        if (!draw_en_i) begin
          // Abort: drop the rest so no write races the VRAM copy.
          state_d = StIdle;
          addr_d  = '0;
          data_d  = '0;
        end else if (x_q == x_last_q) begin
          if (y_q == y_last_q) begin
            state_d = StDone;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            x_d        = x0_q;
            y_d        = y_q + Y_WIDTH'(1);
            row_base_d = row_base_q + RowStride;
            addr_d     = row_base_q + RowStride + ADDR_WIDTH'(x0_q);
          end
        end else begin
          x_d    = x_q + X_WIDTH'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      x_q        <= '0;
      x0_q       <= '0;
      x_last_q   <= '0;
      y_q        <= '0;
      y_last_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      x0_q       <= x0_d;
      x_last_q   <= x_last_d;
      y_q        <= y_d;
      y_last_q   <= y_last_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

`ifdef SAND_BRUSH_SCATTER_EN
  // Galois LFSR. It steps on every PAINT cycle, so the walk timing is
  // unchanged and only the write strobe is thinned.
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StPaint) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign scatter_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign scatter_ok = 1'b1;
`endif

  assign ram_wr_en_o      = (state_q == StPaint) & draw_en_i & scatter_ok;
  assign ram_wr_address_o = addr_q;
  assign ram_wr_data_o    = data_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);

endmodule
